tile_dispatcher: RTL

//  Upstream feeder for the tile rasterizer. Accepts one screen-space triangle per handshake and computes its

---
 rtl/raster_pkg.sv | 69 ++++++
 rtl/tile_bbox.sv | 51 +++++
 rtl/tile_dispatcher.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared rasterizer types: fixed-point coordinates, tile metadata, tile index helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package raster_pkg;

    localparam int FX_INT_BITS   = 12;
    localparam int FX_FRAC_BITS  = 4;
    localparam int FX_TOTAL_BITS = FX_INT_BITS + FX_FRAC_BITS;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int TILE_SHIFT   = 5;
    localparam int TILE_COLS    = SCREEN_W >> TILE_SHIFT;
    localparam int TILE_ROWS    = SCREEN_H >> TILE_SHIFT;
    localparam int NUM_VERTICES = 3;

    // A 16-bit coordinate shifted down by 9 leaves 7 significant bits (-64..63).
    localparam int TILE_IDX_BITS = FX_TOTAL_BITS - FX_FRAC_BITS - TILE_SHIFT;
    localparam int TX_BITS       = 5;
    localparam int TY_BITS       = 4;

    typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;
    typedef logic signed [TILE_IDX_BITS-1:0] tile_idx_t;

    localparam tile_idx_t TILE_COL_LAST = tile_idx_t'(TILE_COLS - 1);
    localparam tile_idx_t TILE_ROW_LAST = tile_idx_t'(TILE_ROWS - 1);

    typedef struct packed {
        fx_t x;
        fx_t y;
        fx_t z;
    } coord_3d_t;

    typedef struct packed {
        logic [3:0]         color;
        logic [2:0]         padding;
        logic [TY_BITS-1:0] tile_y;
        logic [TX_BITS-1:0] tile_x;
    } metadata_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BBOX = 2'd1,
        S_EMIT = 2'd2
    } disp_state_t;

    function automatic fx_t fx_min3(fx_t a, fx_t b, fx_t c);
        fx_t m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic fx_t fx_max3(fx_t a, fx_t b, fx_t c);
        fx_t m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    // Arithmetic shift floors toward -inf, so a vertex sitting exactly on a
    // tile edge lands in the tile to its right/below (conservative coverage).
    function automatic tile_idx_t tile_idx(fx_t v);
        fx_t s;
        s = v >>> (FX_FRAC_BITS + TILE_SHIFT);
        return s[TILE_IDX_BITS-1:0];
    endfunction

endpackage

// File: rtl/tile_bbox.sv
// Combinational tile-space bounding box of a triangle, clamped to the screen, with off-screen flag.
// Latency: 0 cycles (pure combinational; parent registers the result).
// Backpressure: none.
// Ports: x0..x2/y0..y2 vertex coords (12.4 signed); min/max_tx clamped column range;
//        min/max_ty clamped row range; off_screen set when the box misses the screen entirely.
module tile_bbox
    import raster_pkg::*;
(
    input  fx_t                x0,
    input  fx_t                y0,
    input  fx_t                x1,
    input  fx_t                y1,
    input  fx_t                x2,
    input  fx_t                y2,
    output logic [TX_BITS-1:0] min_tx,
    output logic [TX_BITS-1:0] max_tx,
    output logic [TY_BITS-1:0] min_ty,
    output logic [TY_BITS-1:0] max_ty,
    output logic               off_screen
);

    tile_idx_t min_tx_s, max_tx_s, min_ty_s, max_ty_s;

    always_comb begin
        min_tx_s = tile_idx(fx_min3(x0, x1, x2));
        max_tx_s = tile_idx(fx_max3(x0, x1, x2));
        min_ty_s = tile_idx(fx_min3(y0, y1, y2));
        max_ty_s = tile_idx(fx_max3(y0, y1, y2));

        off_screen = max_tx_s[TILE_IDX_BITS-1] || (min_tx_s > TILE_COL_LAST) ||
                     max_ty_s[TILE_IDX_BITS-1] || (min_ty_s > TILE_ROW_LAST);

        // Clamp each bound independently into [0, LAST].
        if (min_tx_s[TILE_IDX_BITS-1])     min_tx = '0;
        else if (min_tx_s > TILE_COL_LAST) min_tx = TILE_COL_LAST[TX_BITS-1:0];
        else                               min_tx = min_tx_s[TX_BITS-1:0];

        if (max_tx_s[TILE_IDX_BITS-1])     max_tx = '0;
        else if (max_tx_s > TILE_COL_LAST) max_tx = TILE_COL_LAST[TX_BITS-1:0];
        else                               max_tx = max_tx_s[TX_BITS-1:0];

        if (min_ty_s[TILE_IDX_BITS-1])     min_ty = '0;
        else if (min_ty_s > TILE_ROW_LAST) min_ty = TILE_ROW_LAST[TY_BITS-1:0];
        else                               min_ty = min_ty_s[TY_BITS-1:0];

        if (max_ty_s[TILE_IDX_BITS-1])     max_ty = '0;
        else if (max_ty_s > TILE_ROW_LAST) max_ty = TILE_ROW_LAST[TY_BITS-1:0];
        else                               max_ty = max_ty_s[TY_BITS-1:0];
    end

endmodule

// File: rtl/tile_dispatcher.sv
// Accepts one triangle, computes its clamped tile bounding box and emits one beat per tile in raster order.
// Latency: accept at edge N -> first vld_out sampled at N+2; tri_rdy returns one edge after the last beat.
// Backpressure: beat held stable while vld_out & !ready_in; tri_rdy low for the whole triangle.
// Ports: tri_vld/tri_rdy/tri_v0..2/tri_color upstream triangle handshake; ready_in/vld_out/v0..2_out/
//        metadata/last_out rasterizer beat interface; busy high whenever not idle.
module tile_dispatcher
    import raster_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tri_vld,
    output logic       tri_rdy,
    input  coord_3d_t  tri_v0,
    input  coord_3d_t  tri_v1,
    input  coord_3d_t  tri_v2,
    input  logic [3:0] tri_color,
    input  logic       ready_in,
    output logic       vld_out,
    output coord_3d_t  v0_out,
    output coord_3d_t  v1_out,
    output coord_3d_t  v2_out,
    output metadata_t  metadata,
    output logic       last_out,
    output logic       busy
);

    disp_state_t        state_q, state_d;
    coord_3d_t          v0_d, v1_d, v2_d;
    metadata_t          meta_d;
    logic               vld_d, last_d;
    logic [TX_BITS-1:0] min_tx_q, min_tx_d, max_tx_q, max_tx_d;
    logic [TY_BITS-1:0] max_ty_q, max_ty_d;
    logic [TX_BITS-1:0] nx;
    logic [TY_BITS-1:0] ny;

    logic [TX_BITS-1:0] bb_min_tx, bb_max_tx;
    logic [TY_BITS-1:0] bb_min_ty, bb_max_ty;
    logic               bb_off;

    // The vertex output registers double as the captured triangle.
    tile_bbox u_bbox (
        .x0         (v0_out.x),
        .y0         (v0_out.y),
        .x1         (v1_out.x),
        .y1         (v1_out.y),
        .x2         (v2_out.x),
        .y2         (v2_out.y),
        .min_tx     (bb_min_tx),
        .max_tx     (bb_max_tx),
        .min_ty     (bb_min_ty),
        .max_ty     (bb_max_ty),
        .off_screen (bb_off)
    );

    // Pure decodes of the state register: no path from any input.
    assign tri_rdy = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            v0_out   <= '0;
            v1_out   <= '0;
            v2_out   <= '0;
            metadata <= '0;
            vld_out  <= 1'b0;
            last_out <= 1'b0;
            min_tx_q <= '0;
            max_tx_q <= '0;
            max_ty_q <= '0;
        end else begin
            state_q  <= state_d;
            v0_out   <= v0_d;
            v1_out   <= v1_d;
            v2_out   <= v2_d;
            metadata <= meta_d;
            vld_out  <= vld_d;
            last_out <= last_d;
            min_tx_q <= min_tx_d;
            max_tx_q <= max_tx_d;
            max_ty_q <= max_ty_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        v0_d     = v0_out;
        v1_d     = v1_out;
        v2_d     = v2_out;
        meta_d   = metadata;
        vld_d    = vld_out;
        last_d   = last_out;
        min_tx_d = min_tx_q;
        max_tx_d = max_tx_q;
        max_ty_d = max_ty_q;
        nx       = metadata.tile_x;
        ny       = metadata.tile_y;

        case (state_q)
            S_IDLE: begin
                if (tri_vld) begin
                    v0_d         = tri_v0;
                    v1_d         = tri_v1;
                    v2_d         = tri_v2;
                    meta_d       = '0;
                    meta_d.color = tri_color;
                    state_d      = S_BBOX;
                end
            end
            S_BBOX: begin
                min_tx_d = bb_min_tx;
                max_tx_d = bb_max_tx;
                max_ty_d = bb_max_ty;
                if (bb_off) begin
                    state_d = S_IDLE;
                end else begin
                    meta_d.tile_x = bb_min_tx;
                    meta_d.tile_y = bb_min_ty;
                    last_d        = (bb_min_tx == bb_max_tx) && (bb_min_ty == bb_max_ty);
                    vld_d         = 1'b1;
                    state_d       = S_EMIT;
                end
            end
            S_EMIT: begin
                if (ready_in) begin
                    if (last_out) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        if (metadata.tile_x == max_tx_q) begin
                            nx = min_tx_q;
                            ny = metadata.tile_y + 4'd1;
                        end else begin
                            nx = metadata.tile_x + 5'd1;
                        end
                        meta_d.tile_x = nx;
                        meta_d.tile_y = ny;
                        last_d        = (nx == max_tx_q) && (ny == max_ty_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
